fcvt_int_post: RTL and testbench
================================

Name: fcvt_int_post

Overview:
- Iterative back end for fp->int conversions (FCVT.W/WU/L/LU).
- Consumes the front-end conversion outputs: sign, calculated exponent Ce, LZC input field, special-case flags.
- Shifts the mantissa serially, rounds per the RISC-V rounding mode, saturates, and returns an XLEN integer plus NV/NX flags over a valid/ready handshake.
- Sits between the FPU conversion front end and the FPU result/flag writeback mux.

Parameters:
XLEN, 64, integer result width (32 or 64)
NE, 11, exponent width of the widest supported format
CVTLEN, 64, width of LzcIn field (max of XLEN and NF+1)
STEP, 8, bit positions shifted per SHIFT cycle (power of 2, 1..CVTLEN)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
FlushE  in  1  synchronous abort of any operation in flight
InValid  in  1  request valid
InReady  out  1  block can accept a request
Cs  in  1  sign of input
Ce  in  NE+1  calculated exponent, two's complement (unbiased+1; bias-to-int already applied)
LzcIn  in  CVTLEN  mantissa, leading 1 at MSB for normal inputs
XZero  in  1  input is ±0
XNaN  in  1  input is NaN
XInf  in  1  input is ±inf
Int64  in  1  1=64-bit result, 0=32-bit
Signed  in  1  1=signed result
Frm  in  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM
Mod  in  1  FCVTMOD.W.D request (only honoured with optional feature)
OutValid  out  1  result valid
OutReady  in  1  consumer accepts result
Res  out  XLEN  integer result
FlgNV  out  1  invalid flag
FlgNX  out  1  inexact flag

Behaviour:
- Reset or FlushE: state IDLE; InReady=1, OutValid=0, Res=0, FlgNV=0, FlgNX=0. FlushE wins over a simultaneous accept.
- States: IDLE, SHIFT, ROUND, DONE.
- Accept on InValid&InReady (IDLE only); all inputs registered.
- Shift count N = 0 if Ce negative, else min(Ce, XLEN+33).
  - N=0: next state ROUND.
  - N>0: next state SHIFT.
- Working register W = {XLEN+33 zeros, LzcIn}.
- SHIFT: each cycle W <<= min(remaining, STEP) and remaining is decremented. Go to ROUND when remaining reaches 0.
  - SHIFT lasts ceil(N/STEP) cycles.
- Field split:
  - integer magnitude I = W[CVTLEN+XLEN+32:CVTLEN]
  - guard G = W[CVTLEN-1]
  - sticky S = |W[CVTLEN-2:0]
  - If Ce negative: G=0, S=~XZero.
- ROUND:
  - Round-up increment:
    - RNE: G&(S|I[0])
    - RTZ: 0
    - RDN: Cs&(G|S)
    - RUP: ~Cs&(G|S)
    - RMM: G
  - Magnitude M = I+inc. Signed value = Cs ? -M : M.
  - Range check:
    - Signed limits: [-2^(w-1), 2^(w-1)-1].
    - Unsigned limits: [0, 2^w-1].
    - w = 64 if Int64 else 32.
    - Ce > w+1 counts as out of range.
  - In range: Res = value; FlgNX = G|S; FlgNV = 0.
  - Out of range or XInf: Res saturates toward the input sign; FlgNV = 1, FlgNX = 0.
    - Signed: max/min.
    - Unsigned: 2^w-1 / 0.
  - XNaN: Res = signed/unsigned max; FlgNV = 1.
  - Unsigned with negative nonzero rounded value: Res = 0, NV.
  - Unsigned with negative input rounding to 0: Res = 0, NX only.
  - XZero: Res = 0, no flags.
  - 32-bit results are sign-extended from bit 31 to XLEN, unsigned included.
- DONE: OutValid=1, Res/flags stable. On OutReady go to IDLE; InReady is 1 the following cycle (no same-cycle accept).
- Latency accept->OutValid = ceil(N/STEP)+2 cycles.
- Outputs hold their last value in IDLE until the next DONE.

Optional Feature:
- Macro: FCVT_INT_POST_FCVTMOD_EN
- Defined:
  - Mod=1 forces RTZ and 32-bit signed.
  - Res = low 32 bits of the exact truncated integer (two's complement of I if Cs), sign-extended.
  - NaN/inf: Res = 0.
  - FlgNV = 1 if value is outside int32 range or the input is NaN/inf; else FlgNX = G|S.
  - Needs N up to XLEN+33; beyond that the low bits are 0.
- Undefined:
  - Mod is ignored (treated as 0).
  - N is capped at XLEN+1.

Test Plan:
- 2.5 (Cs=0, Ce=2, LzcIn=0xA000...0), L signed, RNE -> Res=2, NX=1, NV=0; RUP -> 3; latency 3 cycles.
- -2.5 (Cs=1), L signed, RDN -> Res=0xFFFF_FFFF_FFFF_FFFD, NX=1.
- 2^31 (Ce=32), W signed, RTZ -> Res=0x0000_0000_7FFF_FFFF, NV=1, NX=0; with same Ce, WU -> 0xFFFF_FFFF_8000_0000, NV=0.
- -1.0, WU -> Res=0, NV=1; -0.25 (Ce=-1), WU, RTZ -> Res=0, NX=1, NV=0; NaN, L -> 0x7FFF_FFFF_FFFF_FFFF, NV=1.
- Ce=40: OutValid 7 cycles after accept; hold OutReady=0 for 5 cycles -> Res/flags stable, InReady=0; OutReady=1 -> InReady=1 next cycle.
- Assert reset (or FlushE) in 2nd SHIFT cycle -> next cycle IDLE, InReady=1, OutValid=0, Res=0; new request completes normally.

Source files
------------

// File: rtl/fcvt_int_post.sv
// Iterative fp->int conversion back end: serial mantissa shift, RISC-V rounding, saturation.
// Optional FCVTMOD.W.D support is compiled in with FCVT_INT_POST_FCVTMOD_EN.
module fcvt_int_post #(
    parameter int unsigned XLEN   = 64,
    parameter int unsigned NE     = 11,
    parameter int unsigned CVTLEN = 64,
    parameter int unsigned STEP   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              FlushE,
    input  logic              InValid,
    output logic              InReady,
    input  logic              Cs,
    input  logic [NE:0]       Ce,
    input  logic [CVTLEN-1:0] LzcIn,
    input  logic              XZero,
    input  logic              XNaN,
    input  logic              XInf,
    input  logic              Int64,
    input  logic              Signed,
    input  logic [2:0]        Frm,
    input  logic              Mod,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [XLEN-1:0]   Res,
    output logic              FlgNV,
    output logic              FlgNX
);

    localparam int unsigned IW = XLEN + 33;
    localparam int unsigned WW = CVTLEN + IW;
`ifdef FCVT_INT_POST_FCVTMOD_EN
    localparam int unsigned NMax = XLEN + 33;
`else
    localparam int unsigned NMax = XLEN + 1;
`endif
    localparam int unsigned CW = $clog2(XLEN + 34);

    localparam logic [IW:0] One    = (IW+1)'(1);
    localparam logic [IW:0] P31    = One << 31;
    localparam logic [IW:0] P32    = One << 32;
    localparam logic [IW:0] P63    = One << 63;
    localparam logic [IW:0] P64    = One << 64;
    localparam logic [IW:0] SMax32 = P31 - One;
    localparam logic [IW:0] SMax64 = P63 - One;
    localparam logic [IW:0] UMax32 = P32 - One;
    localparam logic [IW:0] UMax64 = P64 - One;

    typedef enum logic [1:0] {StIdle, StShift, StRound, StDone} state_e;

    state_e            state_q, state_d;
    logic [CW-1:0]     rem_q, rem_d;
    logic [WW-1:0]     w_q, w_d;
    logic              cs_q, xzero_q, xnan_q, xinf_q, int64_q, signed_q;
    logic [NE:0]       ce_q;
    logic [2:0]        frm_q;
    logic [XLEN-1:0]   res_q, res_d;
    logic              nv_q, nv_d, nx_q, nx_d;

    logic [CW-1:0]     n_in, amt;
    logic              accept;

    assign accept   = InValid & (state_q == StIdle);
    assign InReady  = (state_q == StIdle);
    assign OutValid = (state_q == StDone);
    assign Res      = res_q;
    assign FlgNV    = nv_q;
    assign FlgNX    = nx_q;

    always_comb begin
        if (Ce[NE]) begin
            n_in = '0;
        end else if (Ce > (NE+1)'(NMax)) begin
            n_in = CW'(NMax);
        end else begin
            n_in = Ce[CW-1:0];
        end
    end

    assign amt = (rem_q > CW'(STEP)) ? CW'(STEP) : rem_q;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        w_d     = w_q;
        case (state_q)
            StIdle: begin
                if (InValid) begin
                    w_d     = {{IW{1'b0}}, LzcIn};
                    rem_d   = n_in;
                    state_d = (n_in == '0) ? StRound : StShift;
                end
            end
            StShift: begin
                w_d   = w_q << amt;
                rem_d = rem_q - amt;
                if (rem_d == '0) begin
                    state_d = StRound;
                end
            end
            StRound: state_d = StDone;
            StDone: begin
                if (OutReady) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Rounding and range check, evaluated while in StRound.
    logic [IW-1:0] int_mag;
    logic [IW:0]   mag, lim_pos, lim_neg;
    logic [63:0]   val, sat_hi, sat_lo, raw, ext;
    logic          ce_neg, guard, sticky, inc, is64, use64, ce_big, in_range;

    assign int_mag = w_q[WW-1:CVTLEN];
    assign ce_neg  = ce_q[NE];
    assign guard   = ce_neg ? 1'b0 : w_q[CVTLEN-1];
    assign sticky  = ce_neg ? ~xzero_q : |w_q[CVTLEN-2:0];
    assign is64    = int64_q & (XLEN == 64);

    always_comb begin
        case (frm_q)
            3'b000:  inc = guard & (sticky | int_mag[0]);
            3'b010:  inc = cs_q & (guard | sticky);
            3'b011:  inc = ~cs_q & (guard | sticky);
            3'b100:  inc = guard;
            default: inc = 1'b0;
        endcase
    end

    assign mag      = {1'b0, int_mag} + {{IW{1'b0}}, inc};
    assign lim_pos  = signed_q ? (is64 ? SMax64 : SMax32) : (is64 ? UMax64 : UMax32);
    assign lim_neg  = signed_q ? (is64 ? P63 : P31) : '0;
    assign ce_big   = ~ce_neg & (ce_q > (is64 ? (NE+1)'(65) : (NE+1)'(33)));
    assign in_range = ~ce_big & (cs_q ? (mag <= lim_neg) : (mag <= lim_pos));
    assign val      = cs_q ? -mag[63:0] : mag[63:0];
    assign sat_hi   = signed_q ? (is64 ? 64'h7FFF_FFFF_FFFF_FFFF : 64'h0000_0000_7FFF_FFFF)
                               : 64'hFFFF_FFFF_FFFF_FFFF;
    assign sat_lo   = signed_q ? (is64 ? 64'h8000_0000_0000_0000 : 64'h0000_0000_8000_0000)
                               : 64'h0;

`ifdef FCVT_INT_POST_FCVTMOD_EN
    logic        mod_q, ce_over, ce_mod_big, mod_in32;
    logic [31:0] mod_tv, mod_lo;

    // Exact truncated value modulo 2^32; beyond the shift cap the low bits are all zero.
    assign ce_over    = ~ce_neg & (ce_q > (NE+1)'(NMax));
    assign ce_mod_big = ~ce_neg & (ce_q > (NE+1)'(33));
    assign mod_tv     = cs_q ? -int_mag[31:0] : int_mag[31:0];
    assign mod_lo     = ce_over ? 32'h0 : mod_tv;
    assign mod_in32   = ~ce_mod_big & (cs_q ? ({1'b0, int_mag} <= P31)
                                            : ({1'b0, int_mag} < P31));
`else
    logic unused_mod;
    assign unused_mod = Mod;
`endif

    always_comb begin
        raw   = '0;
        nv_d  = 1'b0;
        nx_d  = 1'b0;
        use64 = is64;
        if (xnan_q) begin
            raw  = sat_hi;
            nv_d = 1'b1;
        end else if (xinf_q) begin
            raw  = cs_q ? sat_lo : sat_hi;
            nv_d = 1'b1;
        end else if (xzero_q) begin
            raw = '0;
        end else if (!in_range) begin
            raw  = cs_q ? sat_lo : sat_hi;
            nv_d = 1'b1;
        end else begin
            raw  = val;
            nx_d = guard | sticky;
        end
`ifdef FCVT_INT_POST_FCVTMOD_EN
        if (mod_q) begin
            use64 = 1'b0;
            if (xnan_q | xinf_q) begin
                raw  = '0;
                nv_d = 1'b1;
                nx_d = 1'b0;
            end else begin
                raw  = {32'h0, mod_lo};
                nv_d = ~mod_in32;
                nx_d = mod_in32 & (guard | sticky);
            end
        end
`endif
        ext   = use64 ? raw : {{32{raw[31]}}, raw[31:0]};
        res_d = ext[XLEN-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset || FlushE) begin
            state_q  <= StIdle;
            rem_q    <= '0;
            w_q      <= '0;
            cs_q     <= 1'b0;
            ce_q     <= '0;
            xzero_q  <= 1'b0;
            xnan_q   <= 1'b0;
            xinf_q   <= 1'b0;
            int64_q  <= 1'b0;
            signed_q <= 1'b0;
            frm_q    <= '0;
            res_q    <= '0;
            nv_q     <= 1'b0;
            nx_q     <= 1'b0;
`ifdef FCVT_INT_POST_FCVTMOD_EN
            mod_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            w_q     <= w_d;
            if (accept) begin
                cs_q     <= Cs;
                ce_q     <= Ce;
                xzero_q  <= XZero;
                xnan_q   <= XNaN;
                xinf_q   <= XInf;
                int64_q  <= Int64;
                signed_q <= Signed;
                frm_q    <= Frm;
`ifdef FCVT_INT_POST_FCVTMOD_EN
                mod_q    <= Mod;
`endif
            end
            if (state_q == StRound) begin
                res_q <= res_d;
                nv_q  <= nv_d;
                nx_q  <= nx_d;
            end
        end
    end

endmodule

// File: tb/tb_fcvt_int_post.sv
// Directed bench for fcvt_int_post: arithmetic reference model, per-cycle output compare,
// handshake/latency checks, flush and reset abort.
module tb_fcvt_int_post;

    localparam int unsigned XLEN = 64, NE = 11, CVTLEN = 64, STEP = 8;
    localparam logic [2:0] RNE = 3'd0, RTZ = 3'd1, RDN = 3'd2, RUP = 3'd3, RMM = 3'd4;

    logic              clk = 1'b0;
    logic              reset, FlushE, InValid, InReady, Cs, XZero, XNaN, XInf;
    logic              Int64, Signed, Mod, OutValid, OutReady, FlgNV, FlgNX;
    logic [NE:0]       Ce;
    logic [CVTLEN-1:0] LzcIn;
    logic [2:0]        Frm;
    logic [XLEN-1:0]   Res;

    fcvt_int_post #(.XLEN(XLEN), .NE(NE), .CVTLEN(CVTLEN), .STEP(STEP)) dut (
        .clk(clk), .reset(reset), .FlushE(FlushE), .InValid(InValid), .InReady(InReady),
        .Cs(Cs), .Ce(Ce), .LzcIn(LzcIn), .XZero(XZero), .XNaN(XNaN), .XInf(XInf),
        .Int64(Int64), .Signed(Signed), .Frm(Frm), .Mod(Mod), .OutValid(OutValid),
        .OutReady(OutReady), .Res(Res), .FlgNV(FlgNV), .FlgNX(FlgNX)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    typedef struct {
        logic cs; int ce; logic [63:0] lzc;
        logic xz, xn, xi, i64, sg; logic [2:0] frm;
        logic [63:0] res; logic nv, nx;
    } vec_t;
    typedef struct { logic [63:0] res; logic nv, nx; } exp_t;

    exp_t exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    function automatic vec_t mk(input logic cs, input int ce, input logic [63:0] lzc,
                                input logic xz, input logic xn, input logic xi,
                                input logic i64, input logic sg, input logic [2:0] frm,
                                input logic [63:0] res, input logic nv, input logic nx);
        vec_t v;
        v.cs = cs; v.ce = ce; v.lzc = lzc; v.xz = xz; v.xn = xn; v.xi = xi;
        v.i64 = i64; v.sg = sg; v.frm = frm; v.res = res; v.nv = nv; v.nx = nx;
        return v;
    endfunction

    // Value is lzc * 2^(ce-64); round it, then clamp against the target range.
    function automatic exp_t model(input vec_t v);
        exp_t e;
        logic signed [129:0] p, lo, hi, val;
        logic [127:0] ip, rem, half, m;
        logic [63:0] raw;
        logic inexact, up;
        int k, w;
        w  = v.i64 ? 64 : 32;
        p  = 130'sd1 <<< (w - 1);
        lo = v.sg ? -p : 130'sd0;
        hi = v.sg ? p - 130'sd1 : (p <<< 1) - 130'sd1;
        e.nv = 1'b0; e.nx = 1'b0; raw = '0;
        if (v.xn) begin
            raw = hi[63:0]; e.nv = 1'b1;
        end else if (v.xi) begin
            raw = v.cs ? lo[63:0] : hi[63:0]; e.nv = 1'b1;
        end else if (v.xz) begin
            raw = '0;
        end else if (v.ce > 100) begin
            raw = v.cs ? lo[63:0] : hi[63:0]; e.nv = 1'b1;
        end else begin
            if (v.ce >= 64) begin
                ip = {64'd0, v.lzc} << (v.ce - 64); rem = '0; half = 128'd1;
            end else begin
                k = 64 - v.ce;
                if (k > 126) k = 126;
                ip   = {64'd0, v.lzc} >> k;
                rem  = {64'd0, v.lzc} & ((128'd1 << k) - 128'd1);
                half = 128'd1 << (k - 1);
            end
            inexact = (rem != 0);
            case (v.frm)
                RNE:     up = (rem > half) || (rem == half && ip[0]);
                RDN:     up = v.cs & inexact;
                RUP:     up = ~v.cs & inexact;
                RMM:     up = (rem >= half);
                default: up = 1'b0;
            endcase
            m   = ip + 128'(up);
            val = $signed({2'b00, m});
            if (v.cs) val = -val;
            if (val < lo) begin
                raw = lo[63:0]; e.nv = 1'b1;
            end else if (val > hi) begin
                raw = hi[63:0]; e.nv = 1'b1;
            end else begin
                raw = val[63:0]; e.nx = inexact;
            end
        end
        e.res = (w == 64) ? raw : {{32{raw[31]}}, raw[31:0]};
        return e;
    endfunction

    function automatic int exp_lat(input int ce);
        int n;
        n = (ce < 0) ? 0 : ((ce > 65) ? 65 : ce);
        return (n + STEP - 1) / STEP + 2;
    endfunction

    // Compare DUT outputs against the oldest outstanding expectation on every valid cycle.
    always @(negedge clk) begin
        if (!reset && OutValid) begin
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL unexpected OutValid: got Res=%h, expected no result", Res);
            end else begin
                check("result", Res, exp_q[0].res);
                check("flags nv/nx", {FlgNV, FlgNX}, {exp_q[0].nv, exp_q[0].nx});
            end
        end
    end

    task automatic drive(input vec_t v);
        Cs = v.cs; Ce = (NE+1)'(v.ce); LzcIn = v.lzc; XZero = v.xz; XNaN = v.xn;
        XInf = v.xi; Int64 = v.i64; Signed = v.sg; Frm = v.frm;
    endtask

    task automatic wait_ready(input string name);
        for (int i = 0; i < 50; i++) begin
            if (InReady) break;
            @(posedge clk); #1;
        end
        check({name, " ready"}, InReady, 1);
    endtask

    task automatic run(input vec_t v, input int hold, input string name, output int lat);
        exp_t e, d;
        e = model(v);
        check({name, " model res"}, e.res, v.res);
        check({name, " model flags"}, {e.nv, e.nx}, {v.nv, v.nx});
        wait_ready(name);
        drive(v);
        InValid = 1'b1;
        exp_q.push_back(e);
        @(posedge clk); #1;
        InValid = 1'b0;
        lat = 1;
        while (!OutValid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, " latency"}, lat, exp_lat(v.ce));
        for (int i = 0; i < hold; i++) begin
            check({name, " hold InReady"}, InReady, 0);
            check({name, " hold OutValid"}, OutValid, 1);
            @(posedge clk); #1;
        end
        OutReady = 1'b1;
        @(posedge clk); #1;
        OutReady = 1'b0;
        if (exp_q.size() > 0) d = exp_q.pop_front();
        check({name, " InReady after"}, InReady, 1);
        check({name, " OutValid after"}, OutValid, 0);
    endtask

    task automatic check_idle_cleared(input string name);
        check({name, " InReady"}, InReady, 1);
        check({name, " OutValid"}, OutValid, 0);
        check({name, " Res"}, Res, 0);
        check({name, " flags"}, {FlgNV, FlgNX}, 0);
    endtask

    initial begin
        vec_t big;
        int lat;
        reset = 1'b1; FlushE = 1'b0; InValid = 1'b0; OutReady = 1'b0; Mod = 1'b0;
        Cs = 0; Ce = '0; LzcIn = '0; XZero = 0; XNaN = 0; XInf = 0; Int64 = 0; Signed = 0;
        Frm = RNE;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check_idle_cleared("reset");

        run(mk(0, 2, 64'hA000_0000_0000_0000, 0, 0, 0, 1, 1, RNE,
               64'h2, 0, 1), 0, "2.5 L rne", lat);
        check("2.5 latency literal", lat, 3);
        run(mk(0, 2, 64'hA000_0000_0000_0000, 0, 0, 0, 1, 1, RUP,
               64'h3, 0, 1), 0, "2.5 L rup", lat);
        run(mk(1, 2, 64'hA000_0000_0000_0000, 0, 0, 0, 1, 1, RDN,
               64'hFFFF_FFFF_FFFF_FFFD, 0, 1), 0, "-2.5 L rdn", lat);
        run(mk(0, 32, 64'h8000_0000_0000_0000, 0, 0, 0, 0, 1, RTZ,
               64'h0000_0000_7FFF_FFFF, 1, 0), 0, "2^31 W", lat);
        run(mk(0, 32, 64'h8000_0000_0000_0000, 0, 0, 0, 0, 0, RTZ,
               64'hFFFF_FFFF_8000_0000, 0, 0), 0, "2^31 WU", lat);
        run(mk(1, 1, 64'h8000_0000_0000_0000, 0, 0, 0, 0, 0, RTZ,
               64'h0, 1, 0), 0, "-1 WU", lat);
        run(mk(1, -1, 64'h8000_0000_0000_0000, 0, 0, 0, 0, 0, RTZ,
               64'h0, 0, 1), 0, "-0.25 WU", lat);
        run(mk(0, 0, 64'h0, 0, 1, 0, 1, 1, RNE,
               64'h7FFF_FFFF_FFFF_FFFF, 1, 0), 0, "NaN L", lat);

        big = mk(0, 40, 64'h8000_0000_0000_0000, 0, 0, 0, 1, 1, RNE,
                 64'h0000_0080_0000_0000, 0, 0);
        run(big, 5, "ce40 hold", lat);
        check("ce40 latency literal", lat, 7);

        run(mk(1, 0, 64'h0, 0, 0, 1, 1, 0, RNE, 64'h0, 1, 0), 0, "-inf LU", lat);
        run(mk(0, 0, 64'h0, 0, 0, 1, 0, 1, RNE,
               64'h0000_0000_7FFF_FFFF, 1, 0), 0, "+inf W", lat);
        run(mk(1, 0, 64'h0, 1, 0, 0, 0, 1, RNE, 64'h0, 0, 0), 0, "-0 W", lat);
        run(mk(1, 1, 64'hC000_0000_0000_0000, 0, 0, 0, 0, 1, RNE,
               64'hFFFF_FFFF_FFFF_FFFE, 0, 1), 0, "-1.5 W rne", lat);
        run(mk(0, 0, 64'h8000_0000_0000_0000, 0, 0, 0, 1, 1, RMM,
               64'h1, 0, 1), 0, "0.5 rmm", lat);
        run(mk(0, 0, 64'h8000_0000_0000_0000, 0, 0, 0, 1, 1, RNE,
               64'h0, 0, 1), 0, "0.5 rne", lat);
        run(mk(0, 64, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 1, 0, RNE,
               64'hFFFF_FFFF_FFFF_FFFF, 0, 0), 0, "LU max", lat);
        run(mk(0, 65, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 0, 1, 0, RNE,
               64'hFFFF_FFFF_FFFF_FFFF, 1, 0), 0, "LU over", lat);
        run(mk(1, 64, 64'h8000_0000_0000_0000, 0, 0, 0, 1, 1, RTZ,
               64'h8000_0000_0000_0000, 0, 0), 0, "L min", lat);
        run(mk(0, 64, 64'h8000_0000_0000_0000, 0, 0, 0, 1, 1, RTZ,
               64'h7FFF_FFFF_FFFF_FFFF, 1, 0), 0, "L 2^63", lat);
        run(mk(0, -3, 64'h8000_0000_0000_0000, 0, 0, 0, 1, 1, RUP,
               64'h1, 0, 1), 0, "tiny rup", lat);
        run(mk(1, 200, 64'h8000_0000_0000_0000, 0, 0, 0, 1, 1, RNE,
               64'h8000_0000_0000_0000, 1, 0), 0, "huge neg", lat);
        run(mk(0, 1, 64'hE000_0000_0000_0000, 0, 0, 0, 0, 0, RDN,
               64'h1, 0, 1), 0, "1.75 WU rdn", lat);

        // Flush during the second shift cycle.
        wait_ready("flush");
        drive(big);
        InValid = 1'b1;
        @(posedge clk); #1;
        InValid = 1'b0;
        @(posedge clk); #1;
        FlushE = 1'b1;
        @(posedge clk); #1;
        FlushE = 1'b0;
        check_idle_cleared("flush");
        run(big, 0, "after flush", lat);

        // Reset during the second shift cycle.
        wait_ready("reset abort");
        drive(big);
        InValid = 1'b1;
        @(posedge clk); #1;
        InValid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_idle_cleared("reset abort");
        run(mk(0, 2, 64'hA000_0000_0000_0000, 0, 0, 0, 1, 1, RUP,
               64'h3, 0, 1), 0, "after reset", lat);

        // Flush coinciding with a request: the request must be dropped.
        wait_ready("flush+accept");
        drive(big);
        InValid = 1'b1;
        FlushE = 1'b1;
        @(posedge clk); #1;
        InValid = 1'b0;
        FlushE = 1'b0;
        check("flush+accept InReady", InReady, 1);
        repeat (12) @(posedge clk);
        #1;
        check("flush+accept no result", OutValid, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
